mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported RAM between the instruction-fetch path and the data path.
- The fetch path is driven by the control unit's iREN; the data path is driven by dREN/dWEN.
- Data has priority, with a starvation counter that forces an instruction grant after STARVE_MAX back-to-back data grants.
- Sits between the datapath/caches and the RAM model, and follows the RAM's ramstate handshake.

Parameters:
- WORD_W, 32, data width of load/store words.
- ADDR_W, 32, byte address width.
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before the instruction side is forced.
- TIMEOUT_CYC, 64, grant cycles before abort (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  1 = instruction not ready.
- iload  out  WORD_W  instruction data, valid when iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  WORD_W  write data.
- dwait  out  1  1 = data access not complete.
- dload  out  WORD_W  read data, valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- mem_err  out  1  sticky error flag.

Behaviour:
- State register, states IDLE, GNT_I, GNT_D; reset state is IDLE.
- IDLE: if (dREN|dWEN) and starve_cnt<STARVE_MAX, go to GNT_D. Otherwise, if iREN, go to GNT_I. Otherwise stay in IDLE.
- The grant is registered: a request seen in cycle n has RAM enables asserted in cycle n+1.
- GNT_I: ramREN=1, ramaddr=iaddr. Hold the grant until ramstate is ACCESS or ERROR, then return to IDLE. There is exactly one bubble cycle between transactions.
- GNT_D: ramWEN=dWEN, ramREN=dREN&~dWEN (a write wins if both are asserted), ramaddr=daddr, ramstore=dstore. Exit as for GNT_I.
- iwait=0 only in the cycle where state==GNT_I and ramstate==ACCESS; iload=ramload in that cycle, else 0. dwait/dload behave symmetrically for GNT_D.
- ERROR: treated as completion. The requester's wait drops for one cycle, load data is 0, and mem_err sets (sticky until RST).
- starve_cnt, 0..STARVE_MAX, saturating:
  - +1 on a GNT_D completion while iREN=1.
  - Cleared on a GNT_I completion.
  - Cleared in IDLE when iREN=0.
- Requester deasserts mid-grant: the grant is still held to completion, and the wait pulse is ignored.
- Address/data inputs are passed through combinationally while granted; requesters must hold them stable until their wait is low.
- Reset values: state=IDLE, starve_cnt=0, mem_err=0, iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- RST mid-transaction: immediate return to IDLE and all outputs to reset values; the in-flight RAM access is abandoned.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in GNT_I/GNT_D. When it reaches TIMEOUT_CYC without ACCESS/ERROR, the grant is aborted: the requester's wait drops for one cycle with load=0, mem_err sets, and the state returns to IDLE. The counter clears on every grant entry.
- Undefined: no counter; a grant waits indefinitely. The mem_err port still exists and is set only by ERROR.

Decomposition:
- ramstate_t, word_t and the arbiter state enum (arb_state_t) live in cpu_types_pkg.
- The RAM side is bundled in a mem_arbiter_if interface with arb and tb modports.
- No sub-module: a single FSM plus counters.

Test Plan:
- iREN=1 only, iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN=1 with ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C010004 only in the ACCESS cycle.
- iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> data granted first (ramWEN=1, ramstore=0xDEADBEEF); the instruction is granted after the bubble.
- iREN held high, dREN re-asserted after every completion -> exactly 4 data grants, then 1 instruction grant; starve_cnt returns to 0.
- ramstate=ERROR during a data read -> dwait low for 1 cycle, dload=0, mem_err=1 and it stays 1 through later good accesses.
- RST pulse during GNT_D while BUSY -> ramREN/ramWEN drop immediately, iwait=dwait=1; after reset, a new iREN is served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, ramstate stuck at BUSY -> abort at the 8th grant cycle, one-cycle wait pulse, mem_err=1, state returns to IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the memory arbiter: RAM handshake states, word type, arbiter FSM states
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - RAM-side signal bundle of the arbiter, with arbiter and testbench views
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) ();

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport arb (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport tb (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - data-priority arbiter sharing one RAM port between fetch and data paths
// Defining MEM_ARB_TIMEOUT_EN adds an abort after TIMEOUT_CYC grant cycles without completion.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic [SW-1:0] starve_cnt;
  logic          granted;
  logic          timeout;
  logic          done;
  logic          fault;

  mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) ram ();

  assign ram.ramload  = ramload;
  assign ram.ramstate = ramstate_t'(ramstate);
  assign ramREN       = ram.ramREN;
  assign ramWEN       = ram.ramWEN;
  assign ramaddr      = ram.ramaddr;
  assign ramstore     = ram.ramstore;

  assign granted = (state != IDLE);
  assign done    = granted && (ram.ramstate == ACCESS || ram.ramstate == ERROR || timeout);
  // A completion that did not deliver data (RAM error or abort) is a fault
  assign fault   = done && (ram.ramstate != ACCESS);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  // Every grant is preceded by an IDLE cycle, so clearing in IDLE clears on entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt <= '0;
    end else if (!granted) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign timeout = granted && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if ((dREN || dWEN) && (starve_cnt < SW'(STARVE_MAX))) begin
          state_nx = GNT_D;
        end else if (iREN) begin
          state_nx = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ram.ramREN   = 1'b0;
    ram.ramWEN   = 1'b0;
    ram.ramaddr  = '0;
    ram.ramstore = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    case (state)
      GNT_I: begin
        ram.ramREN = 1'b1;
        ram.ramaddr = iaddr;
        iwait = !done;
        if (ram.ramstate == ACCESS) begin
          iload = ram.ramload;
        end
      end
      GNT_D: begin
        ram.ramWEN   = dWEN;
        ram.ramREN   = dREN && !dWEN;
        ram.ramaddr  = daddr;
        ram.ramstore = dstore;
        dwait = !done;
        if (ram.ramstate == ACCESS) begin
          dload = ram.ramload;
        end
      end
      default: ;
    endcase
  end

  // Counts data grants completed while the fetch side is kept waiting
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (state == GNT_I && done) begin
      starve_cnt <= '0;
    end else if (state == GNT_D && done) begin
      if (iREN && (starve_cnt < SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end else if (state == IDLE && !iREN) begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_err <= 1'b0;
    end else if (fault) begin
      mem_err <= 1'b1;
    end
  end

endmodule
